debouncer_sym: RTL and testbench

//  Multi-channel symmetric debouncer: filters both press and release of each input.

---
 rtl/debouncer_sym_if.sv | 21 ++
 rtl/debouncer_sym.sv | 169 ++++++++++++++++
 tb/tb_debouncer_sym.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/debouncer_sym_if.sv
// Pad-side / user-side signal bundle for the symmetric debouncer.
interface debouncer_sym_if #(
    parameter int data_width = 5
);
    logic [data_width-1:0] Buttons_in;
    logic [data_width-1:0] Buttons_out;
    logic [data_width-1:0] Rise_pulse;
    logic [data_width-1:0] Fall_pulse;
    logic [data_width-1:0] Hold_out;
    logic                  Changed;

    modport master (
        output Buttons_in,
        input  Buttons_out, Rise_pulse, Fall_pulse, Hold_out, Changed
    );

    modport slave (
        input  Buttons_in,
        output Buttons_out, Rise_pulse, Fall_pulse, Hold_out, Changed
    );
endinterface

// File: rtl/debouncer_sym.sv
// Multi-channel symmetric debouncer: shared tick prescaler, 2-FF sync,
// per-channel press/release filter with edge pulses and long-press hold flag.
module debouncer_sym_lane #(
    parameter int debounce_ticks = 4,
    parameter int hold_ticks     = 0
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic tick_i,
    input  logic sync_i,
    output logic flip_o,
    output logic state_o,
    output logic rise_o,
    output logic fall_o,
    output logic hold_o
);
    localparam int CW = $clog2(debounce_ticks + 1);
    localparam logic [CW-1:0] CMAX = CW'(debounce_ticks - 1);

    logic          state_q, state_d, rise_q, fall_q, flip;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any clock where the input agrees with the state restarts the window.
    always_comb begin
        cnt_d = cnt_q;
        flip  = 1'b0;
        if (sync_i == state_q) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CMAX) begin
                flip  = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign state_d = state_q ^ flip;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            rise_q  <= flip & ~state_q;
            fall_q  <= flip & state_q;
        end
    end

    generate
        if (hold_ticks > 0) begin : g_hold
            localparam int HW = $clog2(hold_ticks + 1);
            localparam logic [HW-1:0] HMAX = HW'(hold_ticks);
            logic [HW-1:0] hcnt_q, hcnt_d;
            logic          hold_q;

            // Counts only ticks spent already pressed; clears on the release edge.
            always_comb begin
                hcnt_d = hcnt_q;
                if (!state_d)
                    hcnt_d = '0;
                else if (tick_i && state_q && (hcnt_q != HMAX))
                    hcnt_d = hcnt_q + 1'b1;
            end

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    hcnt_q <= '0;
                    hold_q <= 1'b0;
                end else begin
                    hcnt_q <= hcnt_d;
                    hold_q <= (hcnt_d == HMAX);
                end
            end
            assign hold_o = hold_q;
        end else begin : g_nohold
            assign hold_o = 1'b0;
        end
    endgenerate

    assign flip_o  = flip;
    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
endmodule

module debouncer_sym #(
    parameter int data_width       = 5,
    parameter int tick_div         = 1,
    parameter int debounce_ticks   = 4,
    parameter int hold_ticks       = 0,
    parameter int input_active_low = 0
) (
    input  logic      Clk,
    input  logic      Rst_n,
    debouncer_sym_if.slave bus
);
    generate
        if (tick_div < 1 || debounce_ticks < 1) begin : g_bad_param
            $error("debouncer_sym: tick_div and debounce_ticks must be >= 1");
        end
    endgenerate

    logic [data_width-1:0] raw, sync1_q, sync2_q;
    logic [data_width-1:0] flip, state, rise, fall, hold;
    logic                  tick, changed_q;

    assign raw = (input_active_low != 0) ? ~bus.Buttons_in : bus.Buttons_in;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (tick_div == 1) begin : g_tick_every
            assign tick = 1'b1;
        end else begin : g_prescale
            localparam int PW = $clog2(tick_div);
            localparam logic [PW-1:0] PMAX = PW'(tick_div - 1);
            logic [PW-1:0] pcnt_q;

            assign tick = (pcnt_q == PMAX);
            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n)    pcnt_q <= '0;
                else if (tick) pcnt_q <= '0;
                else           pcnt_q <= pcnt_q + 1'b1;
            end
        end

        for (genvar i = 0; i < data_width; i++) begin : g_lane
            debouncer_sym_lane #(
                .debounce_ticks(debounce_ticks),
                .hold_ticks    (hold_ticks)
            ) u_lane (
                .Clk    (Clk),
                .Rst_n  (Rst_n),
                .tick_i (tick),
                .sync_i (sync2_q[i]),
                .flip_o (flip[i]),
                .state_o(state[i]),
                .rise_o (rise[i]),
                .fall_o (fall[i]),
                .hold_o (hold[i])
            );
        end
    endgenerate

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) changed_q <= 1'b0;
        else        changed_q <= |flip;
    end

    assign bus.Buttons_out = state;
    assign bus.Rise_pulse  = rise;
    assign bus.Fall_pulse  = fall;
    assign bus.Hold_out    = hold;
    assign bus.Changed     = changed_q;
endmodule

// File: tb/tb_debouncer_sym.sv
// Bench for debouncer_sym: vector table, corner sequences, and random traffic
// against a sample-window reference model.
module tb_debouncer_sym;
    localparam int D = 4;
    localparam int H = 8;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc;

    always #5 Clk = ~Clk;

    always @(posedge Clk or negedge Rst_n)
        if (!Rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    debouncer_sym_if #(.data_width(4)) ifa ();
    debouncer_sym_if #(.data_width(4)) ifb ();
    debouncer_sym_if #(.data_width(4)) ifc ();

    debouncer_sym #(.data_width(4), .tick_div(1), .debounce_ticks(D), .hold_ticks(H),
                    .input_active_low(0))
        dut_a (.Clk(Clk), .Rst_n(Rst_n), .bus(ifa));
    debouncer_sym #(.data_width(4), .tick_div(3), .debounce_ticks(D), .hold_ticks(H),
                    .input_active_low(0))
        dut_b (.Clk(Clk), .Rst_n(Rst_n), .bus(ifb));
    debouncer_sym #(.data_width(4), .tick_div(1), .debounce_ticks(D), .hold_ticks(H),
                    .input_active_low(1))
        dut_c (.Clk(Clk), .Rst_n(Rst_n), .bus(ifc));

    typedef struct {
        logic [3:0] bin;
        int         n;
        logic [3:0] out, rise, fall, hold;
        logic       chg;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: a channel flips when its last D synchronized samples
    // (input delayed two clocks) all disagree with its current level.
    logic [3:0] m_dly[$];
    logic [3:0] m_sh[$];
    logic [3:0] m_state;
    int         m_rise_at[4];
    int         m_k;

    task automatic model_reset();
        m_dly = {4'h0, 4'h0};
        m_sh.delete();
        repeat (D) m_sh.push_back(4'h0);
        m_state = 4'h0;
        m_k = 0;
    endtask

    task automatic model_edge(input logic [3:0] bin, output logic [16:0] e);
        logic [3:0] s, diff, r, f, h;
        m_k++;
        s = m_dly[0];
        void'(m_dly.pop_front());
        m_dly.push_back(bin);
        m_sh.push_back(s);
        void'(m_sh.pop_front());
        diff = 4'hF;
        foreach (m_sh[j]) diff = diff & (m_sh[j] ^ m_state);
        r = diff & ~m_state;
        f = diff & m_state;
        m_state = m_state ^ diff;
        for (int c = 0; c < 4; c++) begin
            if (r[c]) m_rise_at[c] = m_k;
            h[c] = m_state[c] && ((m_k - m_rise_at[c]) >= H);
        end
        e = {m_state, r, f, h, |diff};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] exp_v;
        logic [3:0]  bin;
        int          n, e, t0, exp_edge, den;

        ifa.Buttons_in = 4'hF;
        ifb.Buttons_in = 4'h0;
        ifc.Buttons_in = 4'hF;

        // Reset with inputs pressed: outputs low, then all press together.
        #3;
        chk("rst_out", 32'(ifa.Buttons_out), 32'h0);
        chk("rst_pulse", 32'({ifa.Rise_pulse, ifa.Fall_pulse, ifa.Hold_out, ifa.Changed}), 32'h0);
        step();
        step();
        Rst_n = 1'b1;
        repeat (5) step();
        chk("t1_out_5", 32'(ifa.Buttons_out), 32'h0);
        step();
        chk("t1_out_6", 32'(ifa.Buttons_out), 32'hF);
        chk("t1_rise", 32'(ifa.Rise_pulse), 32'hF);
        chk("t1_chg", 32'(ifa.Changed), 32'h1);
        step();
        chk("t1_rise_off", 32'({ifa.Rise_pulse, ifa.Changed}), 32'h0);

        tbl.push_back(vec_t'{4'hF, 7, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0});
        tbl.push_back(vec_t'{4'h0, 5, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0});
        tbl.push_back(vec_t'{4'h0, 1, 4'h0, 4'h0, 4'hF, 4'h0, 1'b1});
        tbl.push_back(vec_t'{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h1, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h0, 7, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h2, 6, 4'h2, 4'h2, 4'h0, 4'h0, 1'b1});
        tbl.push_back(vec_t'{4'h2, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h0, 3, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h2, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h0, 5, 4'h2, 4'h0, 4'h0, 4'h2, 1'b0});
        tbl.push_back(vec_t'{4'h0, 1, 4'h0, 4'h0, 4'h2, 4'h0, 1'b1});
        tbl.push_back(vec_t'{4'h0, 4, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h4, 6, 4'h4, 4'h4, 4'h0, 4'h0, 1'b1});
        tbl.push_back(vec_t'{4'h4, 7, 4'h4, 4'h0, 4'h0, 4'h0, 1'b0});
        tbl.push_back(vec_t'{4'h4, 1, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0});
        tbl.push_back(vec_t'{4'h4, 6, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0});
        tbl.push_back(vec_t'{4'h0, 5, 4'h4, 4'h0, 4'h0, 4'h4, 1'b0});
        tbl.push_back(vec_t'{4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0, 1'b1});
        tbl.push_back(vec_t'{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0});

        for (int i = 0; i < tbl.size(); i++) begin
            ifa.Buttons_in = tbl[i].bin;
            repeat (tbl[i].n) step();
            chk($sformatf("vec%0d_out", i), 32'(ifa.Buttons_out), 32'(tbl[i].out));
            chk($sformatf("vec%0d_rise", i), 32'(ifa.Rise_pulse), 32'(tbl[i].rise));
            chk($sformatf("vec%0d_fall", i), 32'(ifa.Fall_pulse), 32'(tbl[i].fall));
            chk($sformatf("vec%0d_hold", i), 32'(ifa.Hold_out), 32'(tbl[i].hold));
            chk($sformatf("vec%0d_chg", i), 32'(ifa.Changed), 32'(tbl[i].chg));
        end

        // Random traffic on the tick-every-clock instance, fresh from reset.
        Rst_n = 1'b0;
        step();
        Rst_n = 1'b1;
        model_reset();
        bin = 4'h0;
        for (int blk = 0; blk < 8; blk++) begin
            den = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 5 : 14);
            for (int k = 0; k < 100; k++) begin
                for (int c = 0; c < 4; c++)
                    if ($urandom_range(den - 1, 0) == 0) bin[c] = ~bin[c];
                ifa.Buttons_in = bin;
                step();
                model_edge(bin, exp_v);
                chk("rnd", 32'({ifa.Buttons_out, ifa.Rise_pulse, ifa.Fall_pulse,
                                ifa.Hold_out, ifa.Changed}), 32'(exp_v));
            end
        end

        // Prescaled instance: ticks land on edges that are multiples of 3 since reset.
        for (int p = 0; p < 3; p++) begin
            repeat (p) step();
            e = cyc + 1;
            t0 = ((e + 4) / 3) * 3;
            exp_edge = t0 + 3 * (D - 1);
            ifb.Buttons_in = 4'h8;
            n = 0;
            while (ifb.Buttons_out[3] !== 1'b1 && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("p5_edge%0d", p), 32'(cyc), 32'(exp_edge));
            chk($sformatf("p5_lat%0d", p), 32'((n >= 12) && (n <= 14)), 32'h1);
            chk($sformatf("p5_rise%0d", p), 32'(ifb.Rise_pulse), 32'h8);
            ifb.Buttons_in = 4'h0;
            n = 0;
            while (ifb.Buttons_out[3] !== 1'b0 && n < 40) begin
                step();
                n++;
            end
            chk($sformatf("p5_rel%0d", p), 32'(ifb.Buttons_out), 32'h0);
        end

        // Active-low instance: simultaneous presses, then reset mid-release.
        ifc.Buttons_in = 4'h5;
        repeat (5) step();
        chk("t6_out_5", 32'(ifc.Buttons_out), 32'h0);
        step();
        chk("t6_out", 32'(ifc.Buttons_out), 32'hA);
        chk("t6_rise", 32'(ifc.Rise_pulse), 32'hA);
        chk("t6_chg", 32'(ifc.Changed), 32'h1);
        step();
        chk("t6_off", 32'({ifc.Rise_pulse, ifc.Changed}), 32'h0);
        ifc.Buttons_in = 4'hF;
        repeat (3) step();
        chk("t6_mid", 32'(ifc.Buttons_out), 32'hA);
        #2;
        Rst_n = 1'b0;
        #1;
        chk("t6_async", 32'(ifc.Buttons_out), 32'h0);
        #2;
        Rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("t6_quiet", 32'({ifc.Buttons_out, ifc.Rise_pulse, ifc.Fall_pulse,
                                 ifc.Changed}), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
